// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard/stall handshake between the pipeline datapath and the stall controller.
interface pipeline_stall_ctrl_if #(parameter int CNT_W = 32);
  logic             load_use_stall;
  logic             branch_redirect_E;
  logic             md_start_E;
  logic             md_done;
  logic             dmem_ready;
  logic             md_go;
  logic             pc_we;
  logic             ifid_we;
  logic             idex_we;
  logic             exmem_we;
  logic             memwb_we;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic [1:0]       state_o;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  modport master (
    output load_use_stall, branch_redirect_E, md_start_E, md_done, dmem_ready,
    input  md_go, pc_we, ifid_we, idex_we, exmem_we, memwb_we,
    input  ifid_flush, idex_flush, exmem_flush, state_o, md_timeout, stall_cycles, flush_count
  );
  modport slave (
    input  load_use_stall, branch_redirect_E, md_start_E, md_done, dmem_ready,
    output md_go, pc_we, ifid_we, idex_we, exmem_we, memwb_we,
    output ifid_flush, idex_flush, exmem_flush, state_o, md_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stage write-enable/flush decode and mul/div wait FSM with timeout watchdog.
// Optional performance counters are built only when STALL_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input logic                 clk,
  input logic                 reset,
  pipeline_stall_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'b00, MD_WAIT = 2'b01} state_t;
  localparam int CW = $clog2(MD_TIMEOUT);
  localparam logic [CW-1:0] CMAX = CW'(MD_TIMEOUT - 1);
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_done_seen, r_timeout;
  logic            w_in_wait, w_stay;
  logic            w_md_go, w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we;
  logic            w_ifid_flush, w_idex_flush, w_exmem_flush;
  always_comb begin
    w_next        = r_state;
    w_md_go       = 1'b0;
    w_pc_we       = 1'b0;
    w_ifid_we     = 1'b0;
    w_idex_we     = 1'b0;
    w_exmem_we    = 1'b0;
    w_memwb_we    = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    case (r_state)
      RUN: begin
        if (!reset && bus.dmem_ready) begin
          if (bus.load_use_stall || bus.md_start_E) begin
            w_exmem_we    = 1'b1;
            w_exmem_flush = 1'b1;
            w_memwb_we    = 1'b1;
            w_md_go       = !bus.load_use_stall;
            w_next        = bus.load_use_stall ? RUN : MD_WAIT;
          end else begin
            {w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we} = '1;
            w_ifid_flush = bus.branch_redirect_E;
            w_idex_flush = bus.branch_redirect_E;
          end
        end
      end
      MD_WAIT: begin
        if (!reset && bus.dmem_ready) begin
          if (bus.md_done || r_done_seen) begin
            {w_pc_we, w_ifid_we, w_idex_we, w_exmem_we, w_memwb_we} = '1;
            w_next = RUN;
          end else begin
            w_exmem_we    = 1'b1;
            w_exmem_flush = 1'b1;
            w_memwb_we    = 1'b1;
          end
        end
      end
      default: w_next = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= RUN;
    else r_state <= w_next;
  assign w_in_wait = r_state == MD_WAIT;
  assign w_stay    = w_in_wait && w_next == MD_WAIT;
  // done_seen catches a done pulse that arrives while memory is frozen
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt       <= '0;
      r_done_seen <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_cnt       <= !w_stay ? '0 : (r_cnt == CMAX ? r_cnt : r_cnt + CW'(1));
      r_done_seen <= w_stay && (r_done_seen || bus.md_done);
      if (w_in_wait && r_cnt == CMAX) r_timeout <= 1'b1;
    end
  assign bus.md_go       = w_md_go;
  assign bus.pc_we       = w_pc_we;
  assign bus.ifid_we     = w_ifid_we;
  assign bus.idex_we     = w_idex_we;
  assign bus.exmem_we    = w_exmem_we;
  assign bus.memwb_we    = w_memwb_we;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_flush  = w_idex_flush;
  assign bus.exmem_flush = w_exmem_flush;
  assign bus.state_o     = r_state;
  assign bus.md_timeout  = r_timeout;
`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles, r_flush_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_pc_we) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_ifid_flush) r_flush_count <= r_flush_count + CNT_W'(1);
    end
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed checks of stall/flush decode, mul/div wait FSM, watchdog and counters.
module tb_pipeline_stall_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [10:0] snap, exp;
  pipeline_stall_ctrl_if #(.CNT_W(16)) b ();
  pipeline_stall_ctrl #(.MD_TIMEOUT(8), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  // {state(2), md_go, pc/ifid/idex/exmem/memwb we, ifid/idex/exmem flush}
  assign snap = {b.state_o, b.md_go, b.pc_we, b.ifid_we, b.idex_we, b.exmem_we, b.memwb_we,
                 b.ifid_flush, b.idex_flush, b.exmem_flush};
  task automatic drive(input logic lu, input logic br, input logic ms, input logic md, input logic dr);
    @(negedge clk);
    b.load_use_stall    = lu;
    b.branch_redirect_E = br;
    b.md_start_E        = ms;
    b.md_done           = md;
    b.dmem_ready        = dr;
    #1;
  endtask
  task automatic test_reset;
    b.load_use_stall = 1'b0; b.branch_redirect_E = 1'b0; b.md_start_E = 1'b1;
    b.md_done = 1'b0; b.dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp = 11'b00_0_00000_000; checks++;
    if (snap !== exp) begin errors++; $display("FAIL reset_outputs: got %b expected %b", snap, exp); end
    checks++;
    if ({b.md_timeout, b.stall_cycles, b.flush_count} !== 33'd0) begin
      errors++; $display("FAIL reset_regs: got %b/%0d/%0d expected 0/0/0", b.md_timeout, b.stall_cycles, b.flush_count);
    end
    @(negedge clk);
    reset = 1'b0; b.md_start_E = 1'b0;
    #1;
    exp = 11'b00_0_11111_000; checks++;
    if (snap !== exp) begin errors++; $display("FAIL reset_release: got %b expected %b", snap, exp); end
  endtask
  task automatic test_load_use;
    drive(1, 0, 0, 0, 1);
    exp = 11'b00_0_00011_001; checks++;
    if (snap !== exp) begin errors++; $display("FAIL lu_stall: got %b expected %b", snap, exp); end
    drive(0, 0, 0, 0, 1);
    exp = 11'b00_0_11111_000; checks++;
    if (snap !== exp) begin errors++; $display("FAIL lu_after: got %b expected %b", snap, exp); end
  endtask
  task automatic test_lu_redirect;
    drive(1, 1, 0, 0, 1);
    exp = 11'b00_0_00011_001; checks++;
    if (snap !== exp) begin errors++; $display("FAIL lu_redir_stall: got %b expected %b", snap, exp); end
    drive(0, 1, 0, 0, 1);
    exp = 11'b00_0_11111_110; checks++;
    if (snap !== exp) begin errors++; $display("FAIL lu_redir_flush: got %b expected %b", snap, exp); end
  endtask
  task automatic test_freeze;
    drive(1, 1, 1, 0, 0);
    exp = 11'b00_0_00000_000; checks++;
    if (snap !== exp) begin errors++; $display("FAIL freeze: got %b expected %b", snap, exp); end
    drive(0, 0, 0, 0, 1);
    exp = 11'b00_0_11111_000; checks++;
    if (snap !== exp) begin errors++; $display("FAIL freeze_after: got %b expected %b", snap, exp); end
  endtask
  task automatic test_md_wait;
    drive(0, 0, 1, 0, 1);
    exp = 11'b00_1_00011_001; checks++;
    if (snap !== exp) begin errors++; $display("FAIL md_go: got %b expected %b", snap, exp); end
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 1, 0, 1);
      exp = 11'b01_0_00011_001; checks++;
      if (snap !== exp) begin errors++; $display("FAIL md_hold%0d: got %b expected %b", i, snap, exp); end
    end
    drive(0, 0, 1, 1, 1);
    exp = 11'b01_0_11111_000; checks++;
    if (snap !== exp) begin errors++; $display("FAIL md_release: got %b expected %b", snap, exp); end
    drive(0, 0, 0, 0, 1);
    exp = 11'b00_0_11111_000; checks++;
    if (snap !== exp) begin errors++; $display("FAIL md_run: got %b expected %b", snap, exp); end
  endtask
  task automatic test_done_seen;
    drive(0, 0, 1, 0, 1);
    exp = 11'b00_1_00011_001; checks++;
    if (snap !== exp) begin errors++; $display("FAIL ds_go: got %b expected %b", snap, exp); end
    drive(0, 0, 0, 0, 1);
    exp = 11'b01_0_00011_001; checks++;
    if (snap !== exp) begin errors++; $display("FAIL ds_hold: got %b expected %b", snap, exp); end
    drive(0, 0, 0, 1, 0);
    exp = 11'b01_0_00000_000; checks++;
    if (snap !== exp) begin errors++; $display("FAIL ds_frozen_done: got %b expected %b", snap, exp); end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (snap !== exp) begin errors++; $display("FAIL ds_frozen: got %b expected %b", snap, exp); end
    drive(0, 0, 0, 0, 1);
    exp = 11'b01_0_11111_000; checks++;
    if (snap !== exp) begin errors++; $display("FAIL ds_release: got %b expected %b", snap, exp); end
    drive(0, 0, 0, 0, 1);
    exp = 11'b00_0_11111_000; checks++;
    if (snap !== exp) begin errors++; $display("FAIL ds_run: got %b expected %b", snap, exp); end
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 1);
      exp = 11'b00_1_00011_001; checks++;
      if (snap !== exp) begin errors++; $display("FAIL b2b_go%0d: got %b expected %b", i, snap, exp); end
      drive(0, 0, 1, 1, 1);
      exp = 11'b01_0_11111_000; checks++;
      if (snap !== exp) begin errors++; $display("FAIL b2b_release%0d: got %b expected %b", i, snap, exp); end
    end
    drive(0, 0, 0, 0, 1);
    exp = 11'b00_0_11111_000; checks++;
    if (snap !== exp) begin errors++; $display("FAIL b2b_run: got %b expected %b", snap, exp); end
  endtask
  task automatic test_timeout;
    drive(0, 0, 1, 0, 1);
    exp = 11'b00_1_00011_001; checks++;
    if (snap !== exp) begin errors++; $display("FAIL to_go: got %b expected %b", snap, exp); end
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 0, 1);
      exp = 11'b01_0_00011_001; checks++;
      if ({snap, b.md_timeout} !== {exp, k > 8}) begin
        errors++; $display("FAIL to_cycle%0d: got %b/%b expected %b/%b", k, snap, b.md_timeout, exp, k > 8);
      end
    end
    reset = 1'b1;
    #1;
    exp = 11'b00_0_00000_000; checks++;
    if ({snap, b.md_timeout} !== {exp, 1'b0}) begin
      errors++; $display("FAIL to_async_reset: got %b/%b expected %b/0", snap, b.md_timeout, exp);
    end
    b.md_start_E = 1'b0; b.dmem_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask
  task automatic test_perf;
    repeat (3) drive(1, 0, 0, 0, 1);
    repeat (2) drive(0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    checks++;
`ifdef STALL_PERF_CNT_EN
    if ({b.stall_cycles, b.flush_count} !== {16'd3, 16'd2}) begin
      errors++; $display("FAIL perf_counts: got %0d/%0d expected 3/2", b.stall_cycles, b.flush_count);
    end
`else
    if ({b.stall_cycles, b.flush_count} !== 32'd0) begin
      errors++; $display("FAIL perf_tied: got %0d/%0d expected 0/0", b.stall_cycles, b.flush_count);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_lu_redirect();
    test_freeze();
    test_md_wait();
    test_done_seen();
    test_back_to_back();
    test_timeout();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumer end of the hazard-detection interface in the 5-stage RV32IM pipeline.
- Takes the load-use stall request, the EX-stage branch/jump redirect, the multi-cycle mul/div handshake and the data-memory ready signal.
- Drives the write-enables and flushes of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Owns the mul/div wait state machine and its timeout watchdog.

Parameters:
- MD_TIMEOUT, 64, maximum cycles spent in MD_WAIT before md_timeout is raised (must be ≥2).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- load_use_stall  input  1  stall request from the hazard unit (load in MEM, dependent instruction in EX)
- branch_redirect_E  input  1  taken branch/jump resolved in EX
- md_start_E  input  1  instruction in EX is a multi-cycle mul/div
- md_done  input  1  divider result valid; may be a 1-cycle pulse
- dmem_ready  input  1  data memory can complete this cycle
- md_go  output  1  1-cycle start pulse to the divider
- pc_we, ifid_we, idex_we, exmem_we, memwb_we  output  1 each  stage register write-enables
- ifid_flush, idex_flush, exmem_flush  output  1 each  load a bubble (NOP, control = 0) into the register
- state_o  output  2  FSM state (00 RUN, 01 MD_WAIT)
- md_timeout  output  1  sticky watchdog error
- stall_cycles  output  CNT_W  performance counter (optional)
- flush_count  output  CNT_W  performance counter (optional)

Behaviour:
Reset:
- Reset is asynchronous and active-high. On reset: state = RUN, wait counter = 0, done_seen = 0, md_timeout = 0, counters = 0.
- While reset is high, all *_we = 0, all *_flush = 0, md_go = 0.
- A reset mid-operation abandons any mul/div wait immediately.

Output decode:
- All enables and flushes are combinational from the state, the registered flags and the inputs. Zero-latency decision, same cycle.
- A flush takes effect only when the corresponding *_we = 1.

RUN priority, highest first:
1. !dmem_ready: freeze. All *_we = 0, flushes 0, md_go 0.
2. load_use_stall: pc_we = ifid_we = idex_we = 0; exmem_we = 1 with exmem_flush = 1; memwb_we = 1. This overrides any redirect in the same cycle, because the branch operands are not yet valid.
3. md_start_E: same holds as item 2, plus md_go = 1. Next state is MD_WAIT, wait counter cleared.
4. branch_redirect_E: all we = 1, ifid_flush = idex_flush = 1.
5. Otherwise: all we = 1, no flush.

MD_WAIT:
- done_seen is set on any md_done, including while frozen; it is cleared on exit.
- dmem_ready = 0: freeze all stages. The counter still advances.
- dmem_ready = 1 and (md_done or done_seen): release. All we = 1, no flush. Next state RUN, counter cleared.
  - md_start_E is ignored in this cycle, so the same instruction never retriggers.
  - A back-to-back mul/div re-enters MD_WAIT on the following RUN cycle.
- Otherwise: hold pc/ifid/idex; exmem bubble as in RUN item 2.
- Counter saturates at MD_TIMEOUT-1. Reaching it sets md_timeout, which is sticky until reset. The FSM stays in MD_WAIT until done.

General:
- md_go is asserted only from RUN.
- The FSM has 2 states; state encodings 10 and 11 are illegal and recover to RUN on the next clock.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - stall_cycles increments on every cycle with pc_we = 0 and reset low.
  - flush_count increments on every cycle with ifid_flush = 1.
  - Both wrap at 2^CNT_W.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Test Plan:
- Load-use: load_use_stall = 1 for 1 cycle with dmem_ready = 1 -> pc_we = ifid_we = idex_we = 0, exmem_flush = 1, then all we = 1 next cycle.
- Load-use plus redirect in the same cycle -> stall pattern only (ifid_flush = 0); redirect honoured the next cycle, when ifid_flush = idex_flush = 1.
- md_start_E = 1, md_done pulse 5 cycles later -> md_go for exactly 1 cycle, state_o = 01 for 5 cycles, release cycle all we = 1, then state_o = 00.
- MD_WAIT, md_done pulse while dmem_ready = 0, dmem_ready = 1 two cycles later -> release on the dmem_ready = 1 cycle (done_seen path).
- MD_TIMEOUT = 8, md_done never asserted -> md_timeout rises after 8 cycles in MD_WAIT and stays high. Asserting reset mid-wait -> state_o = 00, md_timeout = 0 asynchronously.
- With STALL_PERF_CNT_EN: 3 load-use cycles + 2 redirects -> stall_cycles = 3, flush_count = 2. Without the macro -> both outputs read 0.
